// File: rtl/ctrl_arbiter_2to1.sv
// Two-port round-robin arbiter onto a single downstream control bus.
// One transaction in flight at a time; all outputs are registered.
module ctrl_arbiter_2to1 #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // upstream port 0
  input  logic [ADDRESS_WIDTH-1:0]  s0_addr,
  input  logic [DATA_WIDTH-1:0]     s0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
  input  logic                      s0_write_req,
  input  logic                      s0_read_req,
  output logic [DATA_WIDTH-1:0]     s0_rdata,
  output logic                      s0_write_done,
  output logic                      s0_read_done,
  output logic [1:0]                s0_resp,
  // upstream port 1
  input  logic [ADDRESS_WIDTH-1:0]  s1_addr,
  input  logic [DATA_WIDTH-1:0]     s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
  input  logic                      s1_write_req,
  input  logic                      s1_read_req,
  output logic [DATA_WIDTH-1:0]     s1_rdata,
  output logic                      s1_write_done,
  output logic                      s1_read_done,
  output logic [1:0]                s1_resp,
  // downstream
  output logic [ADDRESS_WIDTH-1:0]  m_addr,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_write_req,
  output logic                      m_read_req,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic                      m_write_done,
  input  logic                      m_read_done,
  input  logic [1:0]                m_resp
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     prefer_s1_q;
  logic                     port_q;
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_W-1:0]        wstrb_q;
  logic                     m_write_req_q;
  logic                     m_read_req_q;
  logic [CNT_W-1:0]         cnt_q;

  logic [DATA_WIDTH-1:0]    s0_rdata_q;
  logic [1:0]               s0_resp_q;
  logic                     s0_write_done_q;
  logic                     s0_read_done_q;
  logic [DATA_WIDTH-1:0]    s1_rdata_q;
  logic [1:0]               s1_resp_q;
  logic                     s1_write_done_q;
  logic                     s1_read_done_q;

  logic                     s0_any;
  logic                     s1_any;
  logic                     gnt_valid_d;
  logic                     gnt_port_d;
  logic                     gnt_write_d;
  logic [ADDRESS_WIDTH-1:0] gnt_addr_d;
  logic [DATA_WIDTH-1:0]    gnt_wdata_d;
  logic [STRB_W-1:0]        gnt_wstrb_d;
  logic                     done_match;
  logic                     timeout_hit;
  logic [1:0]               cpl_resp_d;
  logic [DATA_WIDTH-1:0]    cpl_rdata_d;

  // Round-robin pick; within a port a pending write beats a pending read.
  always_comb begin
    s0_any      = s0_write_req | s0_read_req;
    s1_any      = s1_write_req | s1_read_req;
    gnt_valid_d = s0_any | s1_any;
    gnt_port_d  = 1'b0;
    if (s0_any && s1_any) begin
      gnt_port_d = prefer_s1_q;
    end else begin
      gnt_port_d = s1_any;
    end
    gnt_write_d = gnt_port_d ? s1_write_req : s0_write_req;
    gnt_addr_d  = gnt_port_d ? s1_addr      : s0_addr;
    gnt_wdata_d = gnt_port_d ? s1_wdata     : s0_wdata;
    gnt_wstrb_d = gnt_port_d ? s1_wstrb     : s0_wstrb;
  end

  always_comb begin
    done_match  = write_q ? m_write_done : m_read_done;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    cpl_resp_d  = done_match ? m_resp  : RESP_SLVERR;
    cpl_rdata_d = done_match ? m_rdata : '0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q         <= IDLE;
      prefer_s1_q     <= 1'b0;
      port_q          <= 1'b0;
      write_q         <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      m_write_req_q   <= 1'b0;
      m_read_req_q    <= 1'b0;
      cnt_q           <= '0;
      s0_rdata_q      <= '0;
      s0_resp_q       <= '0;
      s0_write_done_q <= 1'b0;
      s0_read_done_q  <= 1'b0;
      s1_rdata_q      <= '0;
      s1_resp_q       <= '0;
      s1_write_done_q <= 1'b0;
      s1_read_done_q  <= 1'b0;
    end else begin
      s0_write_done_q <= 1'b0;
      s0_read_done_q  <= 1'b0;
      s1_write_done_q <= 1'b0;
      s1_read_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid_d) begin
            port_q        <= gnt_port_d;
            write_q       <= gnt_write_d;
            addr_q        <= gnt_addr_d;
            wdata_q       <= gnt_wdata_d;
            wstrb_q       <= gnt_wstrb_d;
            m_write_req_q <= gnt_write_d;
            m_read_req_q  <= ~gnt_write_d;
            cnt_q         <= '0;
            prefer_s1_q   <= ~gnt_port_d;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          if (done_match || timeout_hit) begin
            m_write_req_q <= 1'b0;
            m_read_req_q  <= 1'b0;
            state_q       <= DONE;
            // Read data is only ever updated by reads, including a read timeout.
            if (port_q == 1'b0) begin
              s0_resp_q       <= cpl_resp_d;
              s0_write_done_q <= write_q;
              s0_read_done_q  <= ~write_q;
              if (!write_q) begin
                s0_rdata_q <= cpl_rdata_d;
              end
            end else begin
              s1_resp_q       <= cpl_resp_d;
              s1_write_done_q <= write_q;
              s1_read_done_q  <= ~write_q;
              if (!write_q) begin
                s1_rdata_q <= cpl_rdata_d;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_addr        = addr_q;
  assign m_wdata       = wdata_q;
  assign m_wstrb       = wstrb_q;
  assign m_write_req   = m_write_req_q;
  assign m_read_req    = m_read_req_q;
  assign s0_rdata      = s0_rdata_q;
  assign s0_resp       = s0_resp_q;
  assign s0_write_done = s0_write_done_q;
  assign s0_read_done  = s0_read_done_q;
  assign s1_rdata      = s1_rdata_q;
  assign s1_resp       = s1_resp_q;
  assign s1_write_done = s1_write_done_q;
  assign s1_read_done  = s1_read_done_q;

endmodule

// File: tb/tb_ctrl_arbiter_2to1.sv
// Directed bench for ctrl_arbiter_2to1: inputs driven and outputs sampled 1ns
// after each rising edge, so every check sees the registers of the current cycle.
module tb_ctrl_arbiter_2to1;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] s0_addr, s0_wdata, s0_rdata;
  logic [3:0]  s0_wstrb;
  logic        s0_write_req, s0_read_req, s0_write_done, s0_read_done;
  logic [1:0]  s0_resp;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic [3:0]  s1_wstrb;
  logic        s1_write_req, s1_read_req, s1_write_done, s1_read_done;
  logic [1:0]  s1_resp;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_write_req, m_read_req, m_write_done, m_read_done;
  logic [1:0]  m_resp;

  int testsRun    = 0;
  int testsFailed = 0;
  int highCycles;

  ctrl_arbiter_2to1 #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_write_req(s0_write_req), .s0_read_req(s0_read_req),
    .s0_rdata(s0_rdata), .s0_write_done(s0_write_done),
    .s0_read_done(s0_read_done), .s0_resp(s0_resp),
    .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_write_req(s1_write_req), .s1_read_req(s1_read_req),
    .s1_rdata(s1_rdata), .s1_write_done(s1_write_done),
    .s1_read_done(s1_read_done), .s1_resp(s1_resp),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_write_req(m_write_req), .m_read_req(m_read_req),
    .m_rdata(m_rdata), .m_write_done(m_write_done),
    .m_read_done(m_read_done), .m_resp(m_resp)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic rst);
    ARESET       = rst;
    s0_addr      = '0; s0_wdata = '0; s0_wstrb = '0;
    s0_write_req = 1'b0; s0_read_req = 1'b0;
    s1_addr      = '0; s1_wdata = '0; s1_wstrb = '0;
    s1_write_req = 1'b0; s1_read_req = 1'b0;
    m_rdata      = '0; m_write_done = 1'b0; m_read_done = 1'b0; m_resp = '0;
  endtask

  initial begin
    applyStimulus(1'b1);
    tick(); tick();
    ARESET = 1'b0;
    tick();
    checkOutput("rst_m_write_req", m_write_req, 0);
    checkOutput("rst_m_read_req", m_read_req, 0);
    checkOutput("rst_m_addr", m_addr, 0);
    checkOutput("rst_s0_done", {s0_write_done, s0_read_done}, 0);
    checkOutput("rst_s0_resp", s0_resp, 0);

    // single write from s0, downstream done two cycles after request rises
    s0_addr = 32'h10; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF; s0_write_req = 1'b1;
    tick();
    checkOutput("wr_b1_req", {m_write_req, m_read_req}, 2'b10);
    checkOutput("wr_b1_addr", m_addr, 32'h10);
    checkOutput("wr_b1_wdata", m_wdata, 32'hDEADBEEF);
    checkOutput("wr_b1_wstrb", m_wstrb, 4'hF);
    tick();
    checkOutput("wr_b2_req", m_write_req, 1);
    checkOutput("wr_b2_wdata", m_wdata, 32'hDEADBEEF);
    tick();
    checkOutput("wr_b3_req", m_write_req, 1);
    checkOutput("wr_b3_addr", m_addr, 32'h10);
    m_write_done = 1'b1; m_resp = 2'b00;
    tick();
    checkOutput("wr_done_mreq", m_write_req, 0);
    checkOutput("wr_done_pulse", s0_write_done, 1);
    checkOutput("wr_done_rd", s0_read_done, 0);
    checkOutput("wr_done_resp", s0_resp, 0);
    m_write_done = 1'b0; s0_write_req = 1'b0;
    tick();
    checkOutput("wr_idle_pulse", s0_write_done, 0);

    // spurious downstream done while idle
    m_write_done = 1'b1; m_resp = 2'b11;
    tick();
    checkOutput("spur_s0_done", s0_write_done, 0);
    checkOutput("spur_s1_done", s1_write_done, 0);
    checkOutput("spur_mreq", {m_write_req, m_read_req}, 0);
    m_write_done = 1'b0;
    tick();
    checkOutput("spur_s0_resp", s0_resp, 0);

    // both ports read in the same cycle right after reset
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    s0_addr = 32'h20; s0_read_req = 1'b1;
    s1_addr = 32'h30; s1_read_req = 1'b1;
    tick();
    checkOutput("rr_s0_req", {m_write_req, m_read_req}, 2'b01);
    checkOutput("rr_s0_addr", m_addr, 32'h20);
    m_read_done = 1'b1; m_rdata = 32'h11111111; m_resp = 2'b00;
    tick();
    checkOutput("rr_s0_done", s0_read_done, 1);
    checkOutput("rr_s0_rdata", s0_rdata, 32'h11111111);
    checkOutput("rr_s1_pending", s1_read_done, 0);
    checkOutput("rr_done_mreq", m_read_req, 0);
    m_read_done = 1'b0; m_rdata = 32'hAAAAAAAA; s0_read_req = 1'b0;
    tick();
    checkOutput("rr_idle_mreq", m_read_req, 0);
    checkOutput("rr_s0_hold", s0_rdata, 32'h11111111);
    tick();
    checkOutput("rr_s1_req", m_read_req, 1);
    checkOutput("rr_s1_addr", m_addr, 32'h30);
    m_read_done = 1'b1; m_rdata = 32'h22222222; m_resp = 2'b01;
    tick();
    checkOutput("rr_s1_done", s1_read_done, 1);
    checkOutput("rr_s1_rdata", s1_rdata, 32'h22222222);
    checkOutput("rr_s1_resp", s1_resp, 2'b01);
    checkOutput("rr_s0_nodone", s0_read_done, 0);
    m_read_done = 1'b0; s1_read_req = 1'b0;
    tick();

    // s1 write and read together: write first, wrong-type done ignored
    s1_addr = 32'h40; s1_wdata = 32'h12345678; s1_wstrb = 4'h3;
    s1_write_req = 1'b1; s1_read_req = 1'b1;
    tick();
    checkOutput("wr_rd_first", {m_write_req, m_read_req}, 2'b10);
    checkOutput("wr_rd_wstrb", m_wstrb, 4'h3);
    m_read_done = 1'b1; m_rdata = 32'h55555555;
    tick();
    checkOutput("wrongtype_req", {m_write_req, m_read_req}, 2'b10);
    checkOutput("wrongtype_nodone", {s1_write_done, s1_read_done}, 0);
    m_read_done = 1'b0; m_write_done = 1'b1; m_resp = 2'b00;
    tick();
    checkOutput("wr_rd_wdone", {s1_write_done, s1_read_done}, 2'b10);
    checkOutput("wr_rd_rdata_kept", s1_rdata, 32'h22222222);
    checkOutput("wr_rd_resp", s1_resp, 0);
    m_write_done = 1'b0; s1_write_req = 1'b0;
    tick();
    checkOutput("wr_rd_gap", {m_write_req, m_read_req}, 0);
    tick();
    checkOutput("wr_rd_second", {m_write_req, m_read_req}, 2'b01);
    m_read_done = 1'b1; m_rdata = 32'h33333333;
    tick();
    checkOutput("wr_rd_rdone", {s1_write_done, s1_read_done}, 2'b01);
    checkOutput("wr_rd_rdata", s1_rdata, 32'h33333333);
    m_read_done = 1'b0; s1_read_req = 1'b0;
    tick();

    // timeout: no downstream done at all
    s0_addr = 32'h50; s0_read_req = 1'b1;
    tick();
    highCycles = 0;
    for (int i = 0; i < 40 && m_read_req; i++) begin
      highCycles++;
      tick();
    end
    checkOutput("to_high_cycles", highCycles, 16);
    checkOutput("to_done", s0_read_done, 1);
    checkOutput("to_resp", s0_resp, 2'b10);
    checkOutput("to_rdata", s0_rdata, 0);
    s0_read_req = 1'b0;
    tick();
    checkOutput("to_idle_pulse", s0_read_done, 0);

    // reset in the second busy cycle, then a clean s1 transaction
    s0_addr = 32'h60; s0_write_req = 1'b1;
    tick();
    tick();
    checkOutput("ab_b2_req", m_write_req, 1);
    ARESET = 1'b1;
    tick();
    checkOutput("ab_mreq", {m_write_req, m_read_req}, 0);
    checkOutput("ab_addr", m_addr, 0);
    checkOutput("ab_s0_done", s0_write_done, 0);
    checkOutput("ab_s0_rdata", s0_rdata, 0);
    checkOutput("ab_s1_rdata", s1_rdata, 0);
    ARESET = 1'b0; s0_write_req = 1'b0;
    tick();
    checkOutput("ab_no_done", {s0_write_done, s0_read_done}, 0);
    s1_addr = 32'h70; s1_read_req = 1'b1;
    tick();
    checkOutput("ab_s1_req", m_read_req, 1);
    checkOutput("ab_s1_addr", m_addr, 32'h70);
    m_read_done = 1'b1; m_rdata = 32'h77; m_resp = 2'b00;
    tick();
    checkOutput("ab_s1_done", s1_read_done, 1);
    checkOutput("ab_s1_rdata2", s1_rdata, 32'h77);
    m_read_done = 1'b0; s1_read_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
